// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter multiplexing NR_MASTERS TCDM requesters onto one shared slave port.
// Grant order rotates past the last winner; a small index FIFO routes in-order responses back.
module tcdm_rr_arbiter #(
    parameter int NR_MASTERS      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_MASTERS-1:0]            m_req_i,
    input  logic [NR_MASTERS*ADDR_WIDTH-1:0] m_add_i,
    input  logic [NR_MASTERS-1:0]            m_wen_i,
    input  logic [NR_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    input  logic [NR_MASTERS*BE_WIDTH-1:0]   m_be_i,
    output logic [NR_MASTERS-1:0]            m_gnt_o,
    output logic [NR_MASTERS-1:0]            m_r_valid_o,
    output logic [DATA_WIDTH-1:0]            m_r_rdata_o,
    output logic                             m_r_opc_o,
    output logic                             s_req_o,
    output logic [ADDR_WIDTH-1:0]            s_add_o,
    output logic                             s_wen_o,
    output logic [DATA_WIDTH-1:0]            s_wdata_o,
    output logic [BE_WIDTH-1:0]              s_be_o,
    input  logic                             s_gnt_i,
    input  logic                             s_r_valid_i,
    input  logic [DATA_WIDTH-1:0]            s_r_rdata_i,
    input  logic                             s_r_opc_i,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int IDX_W = $clog2(NR_MASTERS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_MASTERS - 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] head;
    logic             any_req;
    logic             stall;
    logic             push;
    logic             pop;

    // Search starts at rr_ptr and wraps, so the previous winner gets the lowest priority.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NR_MASTERS; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NR_MASTERS);
            if (!found && m_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |m_req_i;
    assign stall   = (count_q == MAX_CNT) && !s_r_valid_i;
    assign s_req_o = any_req && !stall;
    assign push    = s_req_o && s_gnt_i;
    assign pop     = s_r_valid_i && (count_q != '0);
    assign head    = fifo_q[rd_ptr_q];

    always_comb begin
        s_add_o     = '0;
        s_wen_o     = 1'b1;
        s_wdata_o   = '0;
        s_be_o      = '0;
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        for (int i = 0; i < NR_MASTERS; i++) begin
            if (winner == IDX_W'(i)) begin
                s_add_o    = m_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_wen_o    = m_wen_i[i];
                s_wdata_o  = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_be_o     = m_be_i[i*BE_WIDTH +: BE_WIDTH];
                m_gnt_o[i] = push;
            end
            m_r_valid_o[i] = pop && (head == IDX_W'(i));
        end
    end

    assign m_r_rdata_o = s_r_rdata_i;
    assign m_r_opc_o   = s_r_opc_i;
    assign busy_o      = (count_q != '0);
    assign err_o       = err_q;

    // A response with nothing outstanding is flagged but never touches the FIFO.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (s_r_valid_i && (count_q == '0));
        fifo_d   = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = winner;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            fifo_q   <= '{default: '0};
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: doc/tcdm_rr_arbiter.md
TCDM_RR_ARBITER -- requirements
Module: tcdm_rr_arbiter

Interface
REQ-001 SHALL have parameter NR_MASTERS, default 4, number of TCDM requester ports (2..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width BE_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, response-tracking FIFO depth (1..8).
REQ-005 SHALL have ports:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- m_req_i  in  NR_MASTERS  per-master request.
- m_add_i  in  NR_MASTERS*ADDR_WIDTH  per-master address.
- m_wen_i  in  NR_MASTERS  per-master write-enable, active-low (0 = write).
- m_wdata_i  in  NR_MASTERS*DATA_WIDTH  per-master write data.
- m_be_i  in  NR_MASTERS*BE_WIDTH  per-master byte enables.
- m_gnt_o  out  NR_MASTERS  per-master grant.
- m_r_valid_o  out  NR_MASTERS  per-master response valid.
- m_r_rdata_o  out  DATA_WIDTH  response data, shared by all masters.
- m_r_opc_o  out  1  response error flag, shared by all masters.
- s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/BE_WIDTH  request to the shared slave.
- s_gnt_i  in  1  slave grant.
- s_r_valid_i, s_r_rdata_i, s_r_opc_i  in  1/DATA_WIDTH/1  slave response.
- busy_o  out  1  high while any transaction is outstanding.
- err_o  out  1  sticky protocol-error flag.

Function
REQ-006 SHALL assume slave returns exactly one s_r_valid_i per handshake, in order, at least 1 cycle after it.
REQ-007 Winner SHALL be the first index i with m_req_i[i]=1, searched from rr_ptr upward, wrapping modulo NR_MASTERS; this is combinational.
REQ-008 s_req_o SHALL equal (|m_req_i) AND NOT stall; s_add_o/s_wen_o/s_wdata_o/s_be_o SHALL mux the winner's fields (don't-care when s_req_o=0).
REQ-009 stall SHALL be (count == MAX_OUTSTANDING) AND NOT s_r_valid_i; a push and pop in the same cycle is allowed when full.
REQ-010 m_gnt_o[winner] SHALL equal s_gnt_i AND s_req_o; all other m_gnt_o bits SHALL be 0.
REQ-011 On handshake (s_req_o & s_gnt_i), winner index SHALL be pushed into the FIFO and rr_ptr SHALL become (winner+1) mod NR_MASTERS on the next edge; rr_ptr SHALL otherwise hold.
REQ-012 On s_r_valid_i with count>0, m_r_valid_o[head index] SHALL be 1 in the same cycle, m_r_rdata_o/m_r_opc_o SHALL pass s_r_rdata_i/s_r_opc_i, and head SHALL pop.
REQ-013 Simultaneous push and pop SHALL leave count unchanged, advancing both pointers; pointers SHALL wrap at MAX_OUTSTANDING.
REQ-014 s_r_valid_i with count==0 SHALL set err_o=1 (sticky until reset), assert no m_r_valid_o, and leave FIFO unchanged.
REQ-015 busy_o SHALL be (count != 0), registered-state derived.
REQ-016 Masters SHALL hold request fields stable until granted; the block SHALL NOT buffer requests (zero-latency request path).

Reset
REQ-017 While rst_ni=0: rr_ptr=0, count=0, FIFO pointers=0, err_o=0, busy_o=0; with no inputs active, all m_gnt_o/m_r_valid_o and s_req_o SHALL be 0.
REQ-018 Reset mid-operation SHALL discard outstanding entries; responses arriving after release with count==0 SHALL set err_o per REQ-014.

Verification
REQ-019 All 4 masters request continuously, s_gnt_i=1, slave latency 1 -> grants cycle 0,1,2,3,0...; each master receives its r_valid exactly one cycle after its grant.
REQ-020 Only master 2 requests, rr_ptr=3 -> master 2 granted (wrap); rr_ptr becomes 3.
REQ-021 MAX_OUTSTANDING=2, slave withholds r_valid -> 2 handshakes then s_req_o=0, busy_o=1; r_valid returns and same-cycle push accepted, count stays 2.
REQ-022 Master 1 write (wen=0, be=4'b0011, wdata=32'hDEADBEEF) -> slave sees identical fields; response routed only to master 1.
REQ-023 s_r_valid_i pulse with count=0 -> err_o=1 next cycle, remains until rst_ni low.
REQ-024 Assert rst_ni=0 with 2 outstanding -> busy_o=0, rr_ptr=0 asynchronously; post-reset first grant goes to lowest requesting index.
